// File: rtl/digit_serial_pkg.sv
// Shared type for the digit serializer slice. It holds only the control
// state encoding, which the top-level sequencer uses.
package digit_serial_pkg;

    // IDLE: no word held. SHIFT: a word is being emitted one digit per cycle.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/digit_serializer_if.sv
// Word-in / digit-out bundle for the digit serializer.
// The producer uses the master view. The serializer itself uses the slave view.
interface digit_serializer_if #(
    parameter int W = 4,
    parameter int N = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_a;
    logic [N*W-1:0] in_b;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           first_digit;
    logic           last_digit;
    logic           digit_valid;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, a, b, first_digit, last_digit, digit_valid
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, a, b, first_digit, last_digit, digit_valid
    );
endinterface

// File: rtl/digit_shift_reg.sv
// Parallel-load, right-shifting digit register.
// The current digit is always the low W bits. Each shift moves the next
// more-significant digit into place and backfills with zeros, so the register
// drains to zero after N shifts.
module digit_shift_reg #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           shift,
    input  logic [N*W-1:0] par_in,
    output logic [W-1:0]   digit
);

    logic [N*W-1:0] data;

    // A load takes priority over a shift, so a new word can replace the last
    // digit of the previous word on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= par_in;
        end else if (shift) begin
            data <= data >> W;
        end
    end

    assign digit = data[W-1:0];

endmodule

// File: rtl/digit_serializer.sv
// Converts parallel operand word pairs into aligned digit streams, least
// significant digit first. It marks the first and last digit of each word.
// A new word may load on the edge that retires the previous word's last digit,
// so a continuously valid source sees no bubbles.
module digit_serializer
    import digit_serial_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 4
) (
    input logic              clk,
    input logic              reset,
    digit_serializer_if.slave bus
);

    localparam int               IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    ser_state_t       state;
    logic [IDX_W-1:0] idx;
    logic             first_q;
    logic             last_q;
    logic             valid_q;

    logic             at_last;
    logic             accept;
    logic             do_shift;
    logic [W-1:0]     digit_a;
    logic [W-1:0]     digit_b;

    assign at_last  = (state == SHIFT) && (idx == LAST_IDX);
    assign bus.in_ready = !reset && ((state == IDLE) || at_last);
    assign accept   = bus.in_valid && bus.in_ready;
    assign do_shift = (state == SHIFT) && !accept;

    // Sequencer. It tracks the digit index and registers every flag that
    // goes downstream, so no input reaches the digit outputs combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        idx     <= '0;
                        first_q <= 1'b1;
                        last_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        idx     <= '0;
                        first_q <= 1'b1;
                        last_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else if (at_last) begin
                        state   <= IDLE;
                        idx     <= '0;
                        first_q <= 1'b0;
                        last_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end else begin
                        idx     <= idx + 1'b1;
                        first_q <= 1'b0;
                        last_q  <= ((idx + 1'b1) == LAST_IDX);
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    idx     <= '0;
                    first_q <= 1'b0;
                    last_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    digit_shift_reg #(.W(W), .N(N)) u_shift_a (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .shift  (do_shift),
        .par_in (bus.in_a),
        .digit  (digit_a)
    );

    digit_shift_reg #(.W(W), .N(N)) u_shift_b (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .shift  (do_shift),
        .par_in (bus.in_b),
        .digit  (digit_b)
    );

    assign bus.a           = digit_a;
    assign bus.b           = digit_b;
    assign bus.first_digit = first_q;
    assign bus.last_digit  = last_q;
    assign bus.digit_valid = valid_q;

endmodule

// File: tb/tb_digit_serializer.sv
// Testbench for digit_serializer (W=4, N=4). It compares the DUT against a
// word-level model that tracks the position of the accepted word. It also runs
// a downstream digit-serial adder to exercise the first_digit carry clear.
module tb_digit_serializer;

    localparam int W = 4;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    digit_serializer_if #(.W(W), .N(N)) bus ();

    digit_serializer #(.W(W), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Word-level reference: position of the word being emitted (-1 = none).
    int          m_pos = -1;
    logic [15:0] m_wa  = '0;
    logic [15:0] m_wb  = '0;
    logic        obs_ready;
    logic        exp_ready;

    logic [3:0] single_a [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] single_b [4] = '{4'hF, 4'hF, 4'hF, 4'h0};
    logic [3:0] five_a   [4] = '{4'h5, 4'h0, 4'h0, 4'h0};

    // Downstream digit-serial adder, sampled on the falling edge.
    logic [16:0] add_q[$];
    logic        add_carry = 1'b0;
    logic [15:0] add_sum   = '0;
    int          add_pos   = 0;
    logic [4:0]  add_s;
    int          add_p;

    // This adder consumes the digit stream. Its carry clears on first_digit.
    always @(negedge clk) begin
        if (reset) begin
            add_carry = 1'b0;
            add_pos   = 0;
        end else if (bus.digit_valid) begin
            add_s = 5'(bus.a) + 5'(bus.b) + 5'(bus.first_digit ? 1'b0 : add_carry);
            add_p = bus.first_digit ? 0 : add_pos + 1;
            add_sum[add_p*4 +: 4] = add_s[3:0];
            add_carry = add_s[4];
            add_pos   = add_p;
            if (bus.last_digit) add_q.push_back({add_carry, add_sum});
        end
    end

    function automatic logic [3:0] digit_of(logic [15:0] w, int pos);
        if (pos < 0) return 4'h0;
        return 4'((w >> (W * pos)) & 16'h000F);
    endfunction

    function automatic logic [11:0] model_vec();
        return {exp_ready, digit_of(m_wa, m_pos), digit_of(m_wb, m_pos),
                m_pos == 0, m_pos == N - 1, m_pos >= 0};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {obs_ready, bus.a, bus.b, bus.first_digit, bus.last_digit, bus.digit_valid};
    endfunction

    // This task drives one cycle. It samples in_ready before the edge,
    // advances the model, and returns 1 time unit after the edge.
    task drive_cycle(input logic v, input logic [15:0] wa, input logic [15:0] wb);
        bus.in_valid = v;
        bus.in_a     = wa;
        bus.in_b     = wb;
        #1;
        obs_ready = bus.in_ready;
        exp_ready = (m_pos < 0) || (m_pos == N - 1);
        @(posedge clk);
        if (v && exp_ready) begin
            m_pos = 0;
            m_wa  = wa;
            m_wb  = wb;
        end else if (m_pos == N - 1) begin
            m_pos = -1;
        end else if (m_pos >= 0) begin
            m_pos = m_pos + 1;
        end
        #1;
    endtask

    task idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'($urandom), 16'($urandom));
    endtask

    task test_reset();
        bus.in_valid = 1'b1;
        bus.in_a     = 16'hBEEF;
        bus.in_b     = 16'hCAFE;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec() !== 12'h000 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want 000", {bus.in_ready, dut_vec()});
        end
        bus.in_valid = 1'b0;
        reset = 1'b0;
        m_pos = -1;
        for (int c = 0; c < 2; c++) begin
            drive_cycle(1'b0, 16'($urandom), 16'($urandom));
            n_cmp++;
            if (dut_vec() !== 12'h800) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: got %h want 800", c, dut_vec());
            end
        end
    endtask

    task test_single_word();
        idle(N + 1);
        for (int c = 0; c < 6; c++) begin
            if (c == 0) drive_cycle(1'b1, 16'h1234, 16'h0FFF);
            else        drive_cycle(1'b0, 16'($urandom), 16'($urandom));
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL single_model c%0d: got %h want %h", c, dut_vec(), model_vec());
            end
            n_cmp++;
            if (c < 4) begin
                if ({bus.a, bus.b, bus.first_digit, bus.last_digit, bus.digit_valid} !==
                    {single_a[c], single_b[c], c == 0, c == 3, 1'b1}) begin
                    n_fail++;
                    $display("FAIL single_digit c%0d: got a=%h b=%h f=%b l=%b v=%b want a=%h b=%h",
                             c, bus.a, bus.b, bus.first_digit, bus.last_digit, bus.digit_valid,
                             single_a[c], single_b[c]);
                end
            end else if ({bus.a, bus.b, bus.first_digit, bus.last_digit, bus.digit_valid} !== 11'h0) begin
                n_fail++;
                $display("FAIL single_idle c%0d: got a=%h b=%h v=%b want zeros", c, bus.a, bus.b, bus.digit_valid);
            end
        end
    endtask

    task test_back_to_back();
        idle(N + 1);
        for (int c = 0; c < 9; c++) begin
            drive_cycle(c <= 4, (c == 0) ? 16'h1111 : 16'h2222, (c == 0) ? 16'h1111 : 16'h2222);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL b2b_model c%0d: got %h want %h", c, dut_vec(), model_vec());
            end
            if (c < 8) begin
                n_cmp++;
                if ({obs_ready, bus.a, bus.first_digit, bus.digit_valid} !==
                    {(c == 0) || (c == 4), (c < 4) ? 4'h1 : 4'h2, (c == 0) || (c == 4), 1'b1}) begin
                    n_fail++;
                    $display("FAIL b2b_digit c%0d: got rdy=%b a=%h f=%b v=%b want rdy=%b a=%h",
                             c, obs_ready, bus.a, bus.first_digit, bus.digit_valid,
                             (c == 0) || (c == 4), (c < 4) ? 4'h1 : 4'h2);
                end
            end
        end
    endtask

    task test_held_valid();
        int n_acc;
        n_acc = 0;
        idle(N + 1);
        for (int c = 0; c < 13; c++) begin
            drive_cycle(1'b1, 16'($urandom), 16'($urandom));
            if (obs_ready) n_acc++;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL held_model c%0d: got %h want %h", c, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (n_acc != 4) begin
            n_fail++;
            $display("FAIL held_accepts: got %0d want 4", n_acc);
        end
    endtask

    task test_reset_mid_word();
        idle(N + 1);
        drive_cycle(1'b1, 16'hABCD, 16'h1234);
        n_cmp++;
        if (bus.a !== 4'hD || bus.first_digit !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_d0: got a=%h f=%b want a=d f=1", bus.a, bus.first_digit);
        end
        drive_cycle(1'b0, 16'h0, 16'h0);
        n_cmp++;
        if (bus.a !== 4'hC) begin
            n_fail++;
            $display("FAIL midrst_d1: got a=%h want c", bus.a);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.a, bus.b, bus.first_digit, bus.last_digit, bus.digit_valid} !== 12'h000) begin
            n_fail++;
            $display("FAIL midrst_async: got a=%h b=%h v=%b rdy=%b want zeros",
                     bus.a, bus.b, bus.digit_valid, bus.in_ready);
        end
        m_pos = -1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.a, bus.b, bus.digit_valid} !== 9'h000) begin
            n_fail++;
            $display("FAIL midrst_held: got a=%h b=%h v=%b want zeros", bus.a, bus.b, bus.digit_valid);
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive_cycle(1'b1, 16'h0005, 16'h0000);
            else        drive_cycle(1'b0, 16'($urandom), 16'($urandom));
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL midrst_model c%0d: got %h want %h", c, dut_vec(), model_vec());
            end
            if (c < 4) begin
                n_cmp++;
                if ({bus.a, bus.first_digit, bus.digit_valid} !== {five_a[c], c == 0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL midrst_word c%0d: got a=%h f=%b v=%b want a=%h f=%b",
                             c, bus.a, bus.first_digit, bus.digit_valid, five_a[c], c == 0);
                end
            end
        end
    endtask

    task test_random();
        idle(N + 1);
        for (int c = 0; c < 80; c++) begin
            drive_cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom));
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random_model c%0d: got %h want %h", c, dut_vec(), model_vec());
            end
        end
    endtask

    task test_adder_e2e();
        idle(N + 1);
        add_q.delete();
        drive_cycle(1'b1, 16'hFFFF, 16'h0001);
        for (int c = 0; c < 4; c++) drive_cycle(1'b1, 16'h0001, 16'h0001);
        idle(N + 2);
        n_cmp++;
        if (add_q.size() != 2) begin
            n_fail++;
            $display("FAIL adder_count: got %0d want 2", add_q.size());
        end else begin
            n_cmp++;
            if (add_q[0] !== 17'h1_0000) begin
                n_fail++;
                $display("FAIL adder_sum0: got %h want 10000", add_q[0]);
            end
            n_cmp++;
            if (add_q[1] !== 17'h0_0002) begin
                n_fail++;
                $display("FAIL adder_sum1: got %h want 00002", add_q[1]);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_held_valid();
        test_reset_mid_word();
        test_random();
        test_adder_e2e();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete within time limit");
        $fatal(1, "[TB] stopped");
    end

endmodule

// File: doc/digit_serializer.md
DIGIT_SERIALIZER -- requirements
Module: digit_serializer

Interface
REQ-001 Parameter W, default 4: digit width in bits.
REQ-002 Parameter N, default 4: digits per word; N >= 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand word pair present on in_a/in_b.
REQ-006 in_ready  output  1  block accepts a word pair this cycle.
REQ-007 in_a  input  N*W  operand A, parallel word.
REQ-008 in_b  input  N*W  operand B, parallel word.
REQ-009 a  output  W  current digit of A, least significant digit first.
REQ-010 b  output  W  current digit of B, aligned with a.
REQ-011 first_digit  output  1  a/b carry digit 0 of a word; downstream carry clear.
REQ-012 last_digit  output  1  a/b carry digit N-1 of a word.
REQ-013 digit_valid  output  1  a/b carry a live digit.

Function
REQ-014 The FSM SHALL have two states: IDLE (no word) and SHIFT (emitting digits).
REQ-015 A word SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-016 in_ready SHALL be 1 in IDLE, 1 in SHIFT when digit index = N-1, 0 otherwise, and 0 while reset is asserted.
REQ-017 On acceptance, in_a/in_b SHALL be loaded into shift registers, digit index set to 0, and state set to SHIFT.
REQ-018 Latency: digit 0 SHALL appear on a/b in the cycle after the accepting edge, with first_digit=1 and digit_valid=1.
REQ-019 Each subsequent edge in SHIFT SHALL shift by W bits and increment the digit index, so digit k appears k cycles after digit 0.
REQ-020 a/b SHALL equal bits [k*W +: W] of the accepted in_a/in_b while index = k.
REQ-021 last_digit SHALL be 1 only when index = N-1; first_digit SHALL be 1 only when index = 0 in SHIFT.
REQ-022 At index N-1 with in_valid=1, the next word SHALL load on the same edge, with no idle cycle between words.
REQ-023 At index N-1 with in_valid=0, the block SHALL return to IDLE.
REQ-024 In IDLE, a=0, b=0, first_digit=0, last_digit=0 and digit_valid=0.
REQ-025 in_valid/in_a/in_b SHALL be ignored while in_ready=0; a held in_valid is not accepted early.
REQ-026 a, b, first_digit, last_digit and digit_valid SHALL be driven from registers, with no input-to-output combinational path.

Reset
REQ-027 Reset assertion SHALL immediately force IDLE, index 0, shift registers 0, and all outputs 0.
REQ-028 Reset mid-word SHALL discard the partial word; no digit of it SHALL appear after deassertion.
REQ-029 After deassertion, the first acceptable word SHALL be taken on the first edge with in_valid=1.

Structure
REQ-030 The state enum typedef SHALL live in the shared package digit_serial_pkg.
REQ-031 The state enum typedef SHALL be the only item in digit_serial_pkg.
REQ-032 One sub-module, digit_shift_reg (parameters W, N; load, shift, parallel in, digit out), SHALL be instantiated twice, for A and B.

Verification (W=4, N=4)
REQ-033 Single word: in_a=16'h1234, in_b=16'h0FFF for one cycle, then in_valid=0 -> a = 4,3,2,1 and b = F,F,F,0 on cycles 1-4, first_digit on cycle 1, last_digit on cycle 4, then IDLE zeros.
REQ-034 Back-to-back: words 16'h1111 then 16'h2222 with in_valid held -> eight consecutive valid digits 1,1,1,1,2,2,2,2, with first_digit on digits 1 and 5 and in_ready high on cycles 0 and 4 only.
REQ-035 Held valid: in_valid held high with in_a changing every cycle -> only the values present on acceptance edges are emitted.
REQ-036 Reset mid-word: reset after digit 1 of 16'hABCD -> outputs 0 immediately; the next word 16'h0005 emits 5,0,0,0 with first_digit set.
REQ-037 End-to-end: drive a downstream digit-serial adder with operands 16'hFFFF + 16'h0001, then 16'h0001 + 16'h0001 -> sums 16'h0000 (carry out 1) and 16'h0002, proving first_digit clears the stale carry.
